wtm: RTL and testbench
======================

Name: wtm

Overview:
- Unsigned WIDTH x WIDTH Wallace-tree multiplier with a registered product output.
- Partial products are generated with an AND array.
- Column-wise full/half-adder (3:2 / 2:2) reduction continues until each column has at most two rows.
- A final ripple carry-propagate adder forms the product.
- Used as a standalone arithmetic datapath block.
- Default configuration is 5x5 -> 10-bit product plus carry flag.

Parameters:
- WIDTH, 5, operand width in bits.
  - Supported range 2..8.
  - Product width is 2*WIDTH.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in1  input  WIDTH  unsigned multiplicand.
- in2  input  WIDTH  unsigned multiplier.
- result  output  2*WIDTH  registered unsigned product in1*in2.
- cout  output  1  registered carry out of the final carry-propagate adder (bit 2*WIDTH of its sum).

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - On a rising edge with reset=1: result=0, cout=0.
  - Reset overrides any product in flight. The first valid product appears on the first rising edge after reset deasserts.
- Latency:
  - in1/in2 are sampled at rising edge k; result/cout reflect them after edge k.
  - Latency is 1 cycle (default build).
  - New operands are accepted every cycle. There is no handshake and no enable.
- Partial products: pp[i][j] = in1[j] & in2[i], weight i+j, for i,j in 0..WIDTH-1.
- Reduction:
  - Each stage, per column: group bits in threes into full adders; a leftover pair goes to a half adder only when needed to reach height <=2 in the fewest stages; single bits pass through.
  - Sum outputs stay in the column; carries move to column+1.
  - Stages repeat until every column holds <=2 bits.
  - For WIDTH=5 the stage sequence of maximum column heights is 5 -> 4 -> 3 -> 2.
- Final adder:
  - 2*WIDTH-bit ripple-carry adder over the two remaining rows; empty positions are 0.
  - result = low 2*WIDTH bits of the sum; cout = carry out of the MSB.
- Arithmetic:
  - Purely unsigned; no saturation.
  - Maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits, so cout is 0 for all legal inputs.
  - cout must still be computed from the adder, not tied to 0.
- Boundaries:
  - Either operand 0 -> result 0.
  - Operand = 1 -> result equals the other operand.
  - 31*31 = 961 (0x3C1) with cout=0.
  - X/Z on inputs is not required to be handled.

Optional Feature:
- WTM_PIPE_EN
  - Defined: an extra register stage sits between the end of the Wallace reduction (two rows) and the final adder. Latency becomes 2 cycles, throughput stays 1 per cycle, and reset clears the pipeline registers too.
  - Undefined: a single output register, latency 1.

Decomposition:
- Package wtm_pkg: WIDTH default constant and PROD_W = 2*WIDTH.
- Sub-module wtm_fa: 1-bit full adder (a, b, cin -> sum, cout), instantiated for every reduction cell and every adder bit.
  - Half adders use wtm_fa with cin=0.
- Reduction is built with generate loops in wtm.

Test Plan:
- reset=1 for 2 cycles with in1=31, in2=31 -> result=0, cout=0. Deassert -> next edge result=961, cout=0.
- in1=3, in2=8 -> result=24 (0x018), cout=0 after 1 cycle (2 with WTM_PIPE_EN).
- in1=20, in2=0 -> result=0; then in1=25, in2=16 -> result=400.
- in1=31, in2=1 -> 31; in1=31, in2=3 -> 93; in1=29, in2=7 -> 203; all with cout=0.
- Back-to-back new operand pair every cycle (3*8, 25*16, 29*7) -> results 24, 400, 203 on consecutive cycles at fixed latency.
- Exhaustive 1024-pair sweep against a behavioural in1*in2 model. Assert reset mid-stream -> result=0 on the next edge, and the sweep resumes correctly.

Source files
------------

// File: rtl/wtm_pkg.sv
// rtl/wtm_pkg.sv - widths and elaboration-time Wallace reduction schedule for wtm
package wtm_pkg;

    localparam int DEFAULT_WIDTH  = 5;
    localparam int DEFAULT_PROD_W = 2 * DEFAULT_WIDTH;
    localparam int MAX_COLS       = 17;
    localparam int MAX_STAGES     = 8;

    typedef enum int {
        INFO_HEIGHT,
        INFO_HA,
        INFO_OFFSET
    } info_e;

    function automatic int pp_height(int w, int c);
        int h;
        h = 0;
        if (c >= 0 && c <= 2 * w - 2)
            h = (c < w) ? c + 1 : 2 * w - 1 - c;
        return h;
    endfunction

    // Replays the reduction up to stage s and reports one property of column c.
    // A leftover pair becomes a half adder only if the column would otherwise stay above two.
    function automatic int tree_info(int w, int s, int c, info_e kind);
        int h  [MAX_COLS];
        int nh [MAX_COLS];
        int ha [MAX_COLS];
        int cin;
        int res;
        for (int i = 0; i < MAX_COLS; i++) begin
            h[i]  = pp_height(w, i);
            nh[i] = 0;
            ha[i] = 0;
        end
        for (int st = 0; st <= s; st++) begin
            cin = 0;
            for (int i = 0; i < MAX_COLS; i++) begin
                ha[i] = ((h[i] % 3 == 2) && (h[i] / 3 + 2 + cin > 2)) ? 1 : 0;
                cin   = h[i] / 3 + ha[i];
            end
            if (st < s) begin
                for (int i = 0; i < MAX_COLS; i++) begin
                    nh[i] = h[i] / 3 + h[i] % 3 - ha[i];
                    if (i > 0)
                        nh[i] = nh[i] + h[i - 1] / 3 + ha[i - 1];
                end
                for (int i = 0; i < MAX_COLS; i++)
                    h[i] = nh[i];
            end
        end
        res = 0;
        if (kind == INFO_HEIGHT) begin
            res = h[c];
        end else if (kind == INFO_HA) begin
            res = ha[c];
        end else begin
            for (int i = 0; i < MAX_COLS; i++)
                if (i < c)
                    res = res + h[i];
        end
        return res;
    endfunction

    function automatic int num_stages(int w);
        int mx;
        int res;
        bit found;
        res   = MAX_STAGES;
        found = 1'b0;
        for (int s = 0; s < MAX_STAGES; s++) begin
            mx = 0;
            for (int c = 0; c < 2 * w; c++)
                if (tree_info(w, s, c, INFO_HEIGHT) > mx)
                    mx = tree_info(w, s, c, INFO_HEIGHT);
            if (!found && mx <= 2) begin
                res   = s;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wtm_fa.sv
// rtl/wtm_fa.sv - 1-bit full adder cell; used as a half adder with cin tied low
module wtm_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/wtm.sv
// rtl/wtm.sv - unsigned Wallace-tree multiplier with registered product
// WTM_PIPE_EN adds a register between the two-row reduction output and the final adder.
module wtm
    import wtm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 cout
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int NST    = num_stages(WIDTH);

    // Each stage is one flat vector; column c occupies a contiguous slice at its offset.
    for (genvar s = 0; s <= NST; s++) begin : g_st
        localparam int NB = tree_info(WIDTH, s, PROD_W, INFO_OFFSET);
        logic [NB-1:0] bits;

        if (s == 0) begin : g_pp
            for (genvar i = 0; i < WIDTH; i++) begin : g_row
                for (genvar j = 0; j < WIDTH; j++) begin : g_bit
                    localparam int LO  = (i + j >= WIDTH) ? i + j - WIDTH + 1 : 0;
                    localparam int IDX = tree_info(WIDTH, 0, i + j, INFO_OFFSET) + i - LO;
                    assign bits[IDX] = in1[j] & in2[i];
                end
            end
        end else begin : g_red
            for (genvar c = 0; c < PROD_W; c++) begin : g_col
                localparam int H     = tree_info(WIDTH, s - 1, c, INFO_HEIGHT);
                localparam int NFA   = H / 3;
                localparam int NHA   = tree_info(WIDTH, s - 1, c, INFO_HA);
                localparam int NPASS = H % 3 - 2 * NHA;
                localparam int OI    = tree_info(WIDTH, s - 1, c, INFO_OFFSET);
                localparam int OO    = tree_info(WIDTH, s, c, INFO_OFFSET);
                localparam int HN    = tree_info(WIDTH, s - 1, c + 1, INFO_HEIGHT);
                // Carries land after the next column's own sums and pass-throughs.
                localparam int CO    = tree_info(WIDTH, s, c + 1, INFO_OFFSET) + HN / 3 + HN % 3
                                       - tree_info(WIDTH, s - 1, c + 1, INFO_HA);

                for (genvar k = 0; k < NFA + NHA; k++) begin : g_cell
                    logic s_bit;
                    logic c_bit;
                    logic cin_bit;
                    if (k < NFA) begin : g_fa_in
                        assign cin_bit = g_st[s - 1].bits[OI + 3 * k + 2];
                    end else begin : g_ha_in
                        assign cin_bit = 1'b0;
                    end
                    wtm_fa u_fa (
                        .a    (g_st[s - 1].bits[OI + 3 * k]),
                        .b    (g_st[s - 1].bits[OI + 3 * k + 1]),
                        .cin  (cin_bit),
                        .sum  (s_bit),
                        .cout (c_bit)
                    );
                    assign bits[OO + k] = s_bit;
                    if (c < PROD_W - 1) begin : g_carry
                        assign bits[CO + k] = c_bit;
                    end else begin : g_drop
                        logic unused_carry;
                        assign unused_carry = c_bit;
                    end
                end

                for (genvar p = 0; p < NPASS; p++) begin : g_pass
                    assign bits[OO + NFA + NHA + p] = g_st[s - 1].bits[OI + 3 * NFA + 2 * NHA + p];
                end
            end
        end
    end

    logic [PROD_W-1:0] row_a;
    logic [PROD_W-1:0] row_b;

    for (genvar c = 0; c < PROD_W; c++) begin : g_rows
        localparam int HF = tree_info(WIDTH, NST, c, INFO_HEIGHT);
        localparam int OF = tree_info(WIDTH, NST, c, INFO_OFFSET);
        if (HF >= 1) begin : g_a
            assign row_a[c] = g_st[NST].bits[OF];
        end else begin : g_a0
            assign row_a[c] = 1'b0;
        end
        if (HF >= 2) begin : g_b
            assign row_b[c] = g_st[NST].bits[OF + 1];
        end else begin : g_b0
            assign row_b[c] = 1'b0;
        end
    end

    logic [PROD_W-1:0] add_a;
    logic [PROD_W-1:0] add_b;

`ifdef WTM_PIPE_EN
    logic [PROD_W-1:0] row_a_q;
    logic [PROD_W-1:0] row_b_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_a_q <= '0;
            row_b_q <= '0;
        end else begin
            row_a_q <= row_a;
            row_b_q <= row_b;
        end
    end

    assign add_a = row_a_q;
    assign add_b = row_b_q;
`else
    assign add_a = row_a;
    assign add_b = row_b;
`endif

    logic [PROD_W:0]   carry;
    logic [PROD_W-1:0] sum_w;

    assign carry[0] = 1'b0;

    for (genvar b = 0; b < PROD_W; b++) begin : g_cpa
        wtm_fa u_fa (
            .a    (add_a[b]),
            .b    (add_b[b]),
            .cin  (carry[b]),
            .sum  (sum_w[b]),
            .cout (carry[b + 1])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result <= '0;
            cout   <= 1'b0;
        end else begin
            result <= sum_w;
            cout   <= carry[PROD_W];
        end
    end

endmodule

// File: tb/tb_wtm.sv
// tb/tb_wtm.sv - directed vectors, back-to-back stream and exhaustive sweep for wtm
module tb_wtm;

    localparam int W  = 5;
    localparam int PW = 2 * W;
`ifdef WTM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock;
    logic          reset;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [PW-1:0] result;
    logic          cout;

    int checks;
    int errors;

    logic [PW:0] mp [LAT];

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] res;
        logic          c;
    } vec_t;

    vec_t vecs [11];

    wtm #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .in1    (in1),
        .in2    (in2),
        .result (result),
        .cout   (cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (in1=%0d in2=%0d)", name, act, exp, in1, in2);
        end
    endtask

    // Drive one cycle from the falling edge; the model mirrors only the specified latency and reset behaviour.
    task automatic tick(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        in1   = a;
        in2   = b;
        reset = r;
        @(posedge clock);
        for (int k = LAT - 1; k > 0; k--)
            mp[k] = r ? '0 : mp[k - 1];
        mp[0] = r ? '0 : {1'b0, PW'(a) * PW'(b)};
        @(negedge clock);
    endtask

    initial begin
        logic [PW-1:0] b2b_exp [3];
        logic [W-1:0]  b2b_a   [3];
        logic [W-1:0]  b2b_b   [3];
        int n;
        int idx;

        checks = 0;
        errors = 0;
        for (int k = 0; k < LAT; k++)
            mp[k] = '0;

        vecs[0]  = '{a: 5'd3,  b: 5'd8,  res: 10'd24,  c: 1'b0};
        vecs[1]  = '{a: 5'd20, b: 5'd0,  res: 10'd0,   c: 1'b0};
        vecs[2]  = '{a: 5'd25, b: 5'd16, res: 10'd400, c: 1'b0};
        vecs[3]  = '{a: 5'd31, b: 5'd1,  res: 10'd31,  c: 1'b0};
        vecs[4]  = '{a: 5'd31, b: 5'd3,  res: 10'd93,  c: 1'b0};
        vecs[5]  = '{a: 5'd29, b: 5'd7,  res: 10'd203, c: 1'b0};
        vecs[6]  = '{a: 5'd0,  b: 5'd31, res: 10'd0,   c: 1'b0};
        vecs[7]  = '{a: 5'd1,  b: 5'd29, res: 10'd29,  c: 1'b0};
        vecs[8]  = '{a: 5'd31, b: 5'd31, res: 10'h3C1, c: 1'b0};
        vecs[9]  = '{a: 5'd17, b: 5'd19, res: 10'd323, c: 1'b0};
        vecs[10] = '{a: 5'd16, b: 5'd16, res: 10'd256, c: 1'b0};

        b2b_a[0] = 5'd3;  b2b_b[0] = 5'd8;  b2b_exp[0] = 10'd24;
        b2b_a[1] = 5'd25; b2b_b[1] = 5'd16; b2b_exp[1] = 10'd400;
        b2b_a[2] = 5'd29; b2b_b[2] = 5'd7;  b2b_exp[2] = 10'd203;

        reset = 1'b1;
        in1   = 5'd31;
        in2   = 5'd31;
        @(negedge clock);

        tick(5'd31, 5'd31, 1'b1);
        tick(5'd31, 5'd31, 1'b1);
        check("reset_result", 32'(result), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);

        repeat (LAT) tick(5'd31, 5'd31, 1'b0);
        check("first_result", 32'(result), 32'd961);
        check("first_cout", 32'(cout), 32'd0);

        for (int v = 0; v < 11; v++) begin
            repeat (LAT) tick(vecs[v].a, vecs[v].b, 1'b0);
            check("vec_result", 32'(result), 32'(vecs[v].res));
            check("vec_cout", 32'(cout), 32'(vecs[v].c));
        end

        for (int t = 0; t < 3 + LAT - 1; t++) begin
            idx = (t < 3) ? t : 2;
            tick(b2b_a[idx], b2b_b[idx], 1'b0);
            if (t >= LAT - 1)
                check("b2b_result", 32'(result), 32'(b2b_exp[t - LAT + 1]));
        end

        tick(5'd0, 5'd0, 1'b1);
        n = 0;
        while (n < 1024) begin
            if (n == 500 && reset == 1'b0) begin
                tick(W'(n >> W), W'(n), 1'b1);
                check("mid_reset_result", 32'(result), 32'd0);
                check("mid_reset_cout", 32'(cout), 32'd0);
            end else begin
                tick(W'(n >> W), W'(n), 1'b0);
                check("sweep", 32'({cout, result}), 32'(mp[LAT - 1]));
                n++;
            end
        end
        for (int k = 0; k < LAT - 1; k++) begin
            tick(5'd0, 5'd0, 1'b0);
            check("sweep_drain", 32'({cout, result}), 32'(mp[LAT - 1]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
